// File: rtl/fetch_prefetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit
// and instruction memory: single outstanding request, variable latency.
interface fetch_prefetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns the fetch PC, issues one outstanding imem
// request at a time and buffers returned words in a prefetch queue.
module fetch_prefetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int          DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   fetch_prefetch_unit_if.master    imem,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   input  logic                     stallD,
   output logic                     validF,
   output logic [31:0]              instrF,
   output logic [31:0]              pcPlus4F,
   output logic [$clog2(DEPTH):0]   queue_count
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   localparam logic [0:0] IDLE      = 1'b0;
   localparam logic [0:0] WAIT_RESP = 1'b1;

   logic [0:0]    state;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic          discard;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;
   logic [31:0]   q_instr [DEPTH];
   logic [31:0]   q_pc4   [DEPTH];

   logic grant;
   logic resp;
   logic push;
   logic pop;

   // The credit check keeps a response from ever landing in a full queue.
   always_comb begin
      imem.imem_req  = !reset && (state == IDLE) &&
                       !redirect && (count < FULL);
      imem.imem_addr = fetch_pc;
   end

   assign grant = imem.imem_req && imem.imem_gnt;
   assign resp  = (state == WAIT_RESP) && imem.imem_rvalid;
   assign push  = resp && !discard && !redirect;
   assign pop   = validF && !stallD && !redirect;

   assign validF      = (count != '0);
   assign instrF      = validF ? q_instr[head] : '0;
   assign pcPlus4F    = validF ? q_pc4[head] : '0;
   assign queue_count = count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         discard  <= 1'b0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (redirect) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         if (resp) begin
            state   <= IDLE;
            discard <= 1'b0;
         end else if (state == WAIT_RESP) begin
            discard <= 1'b1;
         end
      end else begin
         if (grant) begin
            state    <= WAIT_RESP;
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (resp) begin
            state   <= IDLE;
            discard <= 1'b0;
         end
         if (push)
            tail <= tail + PTR_ONE;
         if (pop)
            head <= head + PTR_ONE;
         if (push && !pop)
            count <= count + CNT_ONE;
         else if (pop && !push)
            count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_instr[tail] <= imem.imem_rdata;
         q_pc4[tail]   <= req_pc + 32'd4;
      end
   end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction-fetch front end that feeds the fetch→decode pipeline register.
- Owns the fetch PC and issues single-outstanding, variable-latency requests to instruction memory.
- Buffers returned words in a small prefetch queue; decode pops entries when not stalled.
- A taken branch/jump redirects the PC, flushes the queue and discards any in-flight response.

Parameters:
RESET_PC, 32'h0040_0000, fetch address after reset
DEPTH, 4, prefetch queue entries (power of two, ≥2)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch byte address, word aligned
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  32  response instruction word
redirect  input  1  taken branch/jump this cycle
redirect_pc  input  32  new fetch address
stallD  input  1  decode cannot accept an instruction
validF  output  1  queue head valid
instrF  output  32  head instruction; 0 (nop) when empty
pcPlus4F  output  32  head instruction address + 4; 0 when empty
queue_count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset is asynchronous, active-high, on clk domain.
  - Reset values: fetch_pc = RESET_PC; state = IDLE; count = 0; head/tail pointers = 0; discard = 0.
  - Outputs in reset: imem_req = 0, validF = 0, instrF = 0, pcPlus4F = 0, queue_count = 0.
  - Reset mid-request abandons it; a later imem_rvalid in IDLE is ignored.
- State machine: IDLE, WAIT_RESP.
  - IDLE: imem_req = !redirect && (count < DEPTH). imem_addr = fetch_pc.
  - IDLE and imem_req && imem_gnt (same-cycle grant allowed): go to WAIT_RESP; req_pc ← fetch_pc; fetch_pc ← fetch_pc + 4 (mod 2^32, wraps).
  - IDLE and no grant: stay in IDLE; request stays asserted, address stable, until grant or redirect.
  - WAIT_RESP: imem_req = 0. Response arrives no earlier than the cycle after grant.
  - WAIT_RESP and imem_rvalid: go to IDLE. If discard is set, drop the data and clear discard; otherwise push {imem_rdata, req_pc + 4}.
  - imem_rvalid while IDLE: ignored.
- Credit rule: a request issues only when count < DEPTH, with at most one request outstanding.
  - A pop may occur in the same cycle as the response push.
  - Push into a full queue is impossible by construction.
- Queue: registered circular buffer.
  - validF = (count != 0); instrF/pcPlus4F come from the head entry.
  - Pop when validF && !stallD. Simultaneous push and pop leaves count unchanged.
  - Head/tail pointers wrap modulo DEPTH.
- Latency: grant at cycle n, rvalid at n+k (k ≥ 1) → validF high at n+k+1. No bypass from imem_rdata.
- Redirect (priority over every other event in that cycle):
  - Queue is flushed: count ← 0, pointers ← 0. Any pop that cycle is cancelled.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}; misaligned targets are silently aligned.
  - imem_req is forced to 0 that cycle, so an ungranted request is withdrawn.
  - In WAIT_RESP without rvalid that cycle: discard ← 1, and the next response is dropped.
  - In WAIT_RESP with rvalid that cycle: data is dropped, state → IDLE, discard stays 0.
  - Redirect arriving while discard = 1: discard remains 1.
  - First request to the new target issues the cycle after redirect, subject to the IDLE rules.
- stallD has no effect on issuing except through the queue credit.

Test Plan:
1. Reset, then memory grants immediately with 1-cycle response returning 0x20100005 → first imem_addr 0x00400000; validF rises 2 cycles after grant; instrF 0x20100005, pcPlus4F 0x00400004.
2. stallD held high with DEPTH=4 → exactly 4 grants; imem_req low while queue_count=4. Releasing stallD for one cycle pops one entry, and the next request goes to 0x00400010.
3. Redirect to 0x00400100 while in WAIT_RESP; response arrives 3 cycles later → response dropped, queue empty, next imem_addr 0x00400100, validF stays 0 until that instruction returns.
4. Redirect in the same cycle as imem_rvalid with the queue holding 2 entries → queue_count 0 next cycle, no discard pending, next request to the target issues the cycle after.
5. redirect_pc = 0x00400107 → imem_addr 0x00400104, pcPlus4F 0x00400108 when that entry reaches the head.
6. imem_gnt withheld 5 cycles → imem_req and imem_addr stable throughout; fetch_pc advances only on the grant cycle. Asserting reset mid-wait → all outputs 0 and imem_addr returns to 0x00400000 after reset.
